// File: rtl/pmesh_noc2_arbiter.sv
// Round-robin arbiter sharing one pmesh NoC2 request port among NUM_REQ clients,
// with MSHR-id allocation on issue and id-based routing of NoC3 responses.

package pmesh_noc2_pkg;
  localparam int MSHRID_W = 4;

  typedef logic [MSHRID_W-1:0] mshrid_t;
  typedef logic [63:0]         resp_data_t;

  typedef struct packed {
    logic        valid;
    mshrid_t     mshrid;
    logic [4:0]  reqtype;
    logic [39:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
  } pmesh_noc2_o_t;

  typedef struct packed {
    logic ready;
  } pmesh_noc2_i_t;

  typedef struct packed {
    logic       valid;
    mshrid_t    mshrid;
    resp_data_t resp_data;
  } pmesh_noc3_in_t;
endpackage

module pmesh_noc2_arbiter
  import pmesh_noc2_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_MSHR = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  pmesh_noc2_o_t                     req_i [NUM_REQ],
  output pmesh_noc2_o_t                     noc2_o,
  input  pmesh_noc2_i_t                     noc2_i,
  input  pmesh_noc3_in_t                    noc3_i,
  output logic [NUM_REQ-1:0]                resp_valid_o,
  output resp_data_t                        resp_data_o,
  output logic [$clog2(NUM_MSHR+1)-1:0]     outstanding_o,
  output logic                              err_spurious_o
);

  localparam int REQ_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_MSHR+1);

  pmesh_noc2_o_t        noc2_q, noc2_d;
  logic [NUM_MSHR-1:0]  alloc_q, alloc_d;
  logic [REQ_W-1:0]     owner_q [NUM_MSHR];
  logic [REQ_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  resp_data_t           resp_data_q, resp_data_d;
  logic                 err_q, err_d;

  logic                 drain, can_issue;
  logic                 free_found;
  mshrid_t              free_id;
  logic                 grant_valid;
  logic [REQ_W-1:0]     grant_idx, cand, next_ptr;
  logic                 rsp_hit, rsp_spurious;
  logic [REQ_W-1:0]     rsp_owner;
  logic [NUM_MSHR-1:0]  free_mask, alloc_mask;

  // The output register may accept a new request when empty or draining this cycle.
  assign drain     = noc2_q.valid & noc2_i.ready;
  assign can_issue = ~noc2_q.valid | drain;

  // Lowest-indexed free id, taken from the pre-edge pool so a same-cycle free is not reused.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    free_found = 1'b0;
    free_id    = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (!free_found && !alloc_q[i]) begin
        free_found = 1'b1;
        free_id    = mshrid_t'(i);
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (can_issue && free_found) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = REQ_W'((int'(rr_ptr_q) + i) % NUM_REQ);
        if (!grant_valid && req_valid_i[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_valid) req_ready_o[grant_idx] = 1'b1;
  end

  assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + REQ_W'(1);

  // Out-of-range ids never match any pool entry and so fall through to spurious.
  always_comb begin
    rsp_hit   = 1'b0;
    rsp_owner = '0;
    free_mask = '0;
    if (noc3_i.valid) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        if (noc3_i.mshrid == mshrid_t'(i) && alloc_q[i]) begin
          rsp_hit      = 1'b1;
          rsp_owner    = owner_q[i];
          free_mask[i] = 1'b1;
        end
      end
    end
    rsp_spurious = noc3_i.valid & ~rsp_hit;
  end

  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (grant_valid && free_id == mshrid_t'(i)) alloc_mask[i] = 1'b1;
    end
  end

  always_comb begin
    noc2_d = noc2_q;
    if (grant_valid) begin
      noc2_d        = req_i[grant_idx];
      noc2_d.valid  = 1'b1;
      noc2_d.mshrid = free_id;
    end else if (drain) begin
      noc2_d.valid  = 1'b0;
    end

    alloc_d  = (alloc_q & ~free_mask) | alloc_mask;
    rr_ptr_d = grant_valid ? next_ptr : rr_ptr_q;

    unique case ({grant_valid, rsp_hit})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    resp_valid_d = '0;
    if (rsp_hit) resp_valid_d[rsp_owner] = 1'b1;
    resp_data_d = rsp_hit ? noc3_i.resp_data : resp_data_q;
    err_d       = err_q | rsp_spurious;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      noc2_q        <= '0;
      alloc_q       <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      noc2_q        <= noc2_d;
      alloc_q       <= alloc_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      err_q         <= err_d;
    end
  end

  // NOTE: the owner table is not reset; an entry is only read while its alloc bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (alloc_mask[i]) owner_q[i] <= grant_idx;
    end
  end

  assign noc2_o         = noc2_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_data_o    = resp_data_q;
  assign outstanding_o  = outstanding_q;
  assign err_spurious_o = err_q;

endmodule

// File: tb/tb_pmesh_noc2_arbiter.sv
// Self-checking bench for pmesh_noc2_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural pool/round-robin model.

module tb_pmesh_noc2_arbiter;
  import pmesh_noc2_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int NUM_MSHR = 8;
  localparam int CNT_W    = $clog2(NUM_MSHR+1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  pmesh_noc2_o_t        req_i [NUM_REQ];
  pmesh_noc2_o_t        noc2_o;
  pmesh_noc2_i_t        noc2_i;
  pmesh_noc3_in_t       noc3_i;
  logic [NUM_REQ-1:0]   resp_valid_o;
  resp_data_t           resp_data_o;
  logic [CNT_W-1:0]     outstanding_o;
  logic                 err_spurious_o;

  pmesh_noc2_arbiter #(.NUM_REQ(NUM_REQ), .NUM_MSHR(NUM_MSHR)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_i          (req_i),
    .noc2_o         (noc2_o),
    .noc2_i         (noc2_i),
    .noc3_i         (noc3_i),
    .resp_valid_o   (resp_valid_o),
    .resp_data_o    (resp_data_o),
    .outstanding_o  (outstanding_o),
    .err_spurious_o (err_spurious_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: owner per id (-1 = free), round-robin pointer, register image.
  pmesh_noc2_o_t        m_noc2;
  int                   owner [NUM_MSHR];
  int                   m_ptr;
  int                   m_out;
  bit                   m_err;
  logic [NUM_REQ-1:0]   m_rv;
  resp_data_t           m_rd;

  // Requester side: a pending request keeps its payload until accepted.
  pmesh_noc2_o_t        pay [NUM_REQ];
  logic [NUM_REQ-1:0]   pend;

  function automatic pmesh_noc2_o_t rand_pay();
    pmesh_noc2_o_t p;
    p.valid   = 1'($urandom);
    p.mshrid  = mshrid_t'($urandom);
    p.reqtype = 5'($urandom);
    p.addr    = {8'($urandom), $urandom};
    p.size    = 3'($urandom);
    p.data    = {$urandom, $urandom};
    return p;
  endfunction

  task automatic model_reset();
    m_noc2 = '0;
    for (int i = 0; i < NUM_MSHR; i++) owner[i] = -1;
    m_ptr = 0;
    m_out = 0;
    m_err = 1'b0;
    m_rv  = '0;
    m_rd  = '0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    pend        = '0;
    req_valid_i = '0;
    noc2_i      = '0;
    noc3_i      = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      pay[r]   = rand_pay();
      req_i[r] = pay[r];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_noc2",        noc2_o, 0);
    check("rst_req_ready",   req_ready_o, 0);
    check("rst_resp_valid",  resp_valid_o, 0);
    check("rst_resp_data",   resp_data_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_err",         err_spurious_o, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive at negedge, check ready combinationally, advance model, check outputs.
  task automatic step(input bit rdy, input bit rsp_v, input int rsp_id, input resp_data_t rsp_d,
                      output logic [NUM_REQ-1:0] obs_ready);
    int ff, g, c;
    bit hit;
    req_valid_i = pend;
    for (int r = 0; r < NUM_REQ; r++) req_i[r] = pay[r];
    noc2_i.ready     = rdy;
    noc3_i.valid     = rsp_v;
    noc3_i.mshrid    = mshrid_t'(rsp_id);
    noc3_i.resp_data = rsp_d;
    #1;

    ff = -1;
    for (int i = NUM_MSHR - 1; i >= 0; i--) if (owner[i] < 0) ff = i;
    g = -1;
    if ((!m_noc2.valid || rdy) && ff >= 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (m_ptr + k) % NUM_REQ;
        if (g < 0 && pend[c]) g = c;
      end
    end
    obs_ready = req_ready_o;
    check("req_ready", req_ready_o, (g >= 0) ? (128'd1 << g) : 128'd0);

    hit = 1'b0;
    if (rsp_v && rsp_id >= 0 && rsp_id < NUM_MSHR) hit = (owner[rsp_id] >= 0);
    m_rv = '0;
    if (hit) begin
      m_rv[owner[rsp_id]] = 1'b1;
      m_rd = rsp_d;
      owner[rsp_id] = -1;
      m_out--;
    end else if (rsp_v) begin
      m_err = 1'b1;
    end
    if (g >= 0) begin
      m_noc2        = pay[g];
      m_noc2.valid  = 1'b1;
      m_noc2.mshrid = mshrid_t'(ff);
      owner[ff]     = g;
      m_ptr         = (g + 1) % NUM_REQ;
      m_out++;
      pend[g] = 1'b0;
      pay[g]  = rand_pay();
    end else if (m_noc2.valid && rdy) begin
      m_noc2.valid = 1'b0;
    end

    @(posedge clk);
    @(negedge clk);
    check("noc2_valid", noc2_o.valid, m_noc2.valid);
    if (m_noc2.valid) check("noc2_payload", noc2_o, m_noc2);
    check("resp_valid",   resp_valid_o, m_rv);
    check("resp_data",    resp_data_o, m_rd);
    check("outstanding",  outstanding_o, m_out);
    check("err_spurious", err_spurious_o, m_err);
  endtask

  logic [NUM_REQ-1:0] obs;
  pmesh_noc2_o_t      held;
  int                 ids [$];
  int                 pick, rsp_id;
  bit                 rsp_v;

  initial begin
    model_reset();
    do_reset();

    // Idle after reset: nothing issued.
    repeat (3) step(1'b1, 1'b0, 0, '0, obs);
    check("idle_noc2_valid", noc2_o.valid, 0);

    // Fairness: all requesting, ready high.
    for (int i = 0; i < 5; i++) begin
      pend = '1;
      step(1'b1, 1'b0, 0, '0, obs);
      check("fair_grant", obs, 128'd1 << (i % NUM_REQ));
      check("fair_mshrid", noc2_o.mshrid, i);
    end
    check("fair_outstanding", outstanding_o, 5);

    // Backpressure: register held bit-for-bit, no grants.
    held = noc2_o;
    for (int i = 0; i < 3; i++) begin
      pend = '1;
      step(1'b0, 1'b0, 0, '0, obs);
      check("bp_ready", obs, 0);
      check("bp_hold", noc2_o, held);
    end
    pend = '1;
    step(1'b1, 1'b0, 0, '0, obs);
    check("bp_release_grant", obs, 4'b0010);
    check("bp_release_mshrid", noc2_o.mshrid, 5);

    // Fill the pool (ids 6,7 to requesters 2,3), then exhaustion.
    repeat (2) begin
      pend = '1;
      step(1'b1, 1'b0, 0, '0, obs);
    end
    check("full_outstanding", outstanding_o, 8);
    pend = '1;
    step(1'b1, 1'b0, 0, '0, obs);
    check("full_ready", obs, 0);
    check("full_drained", noc2_o.valid, 0);

    // Response on id 5 (owned by requester 1): no same-cycle grant, reuse next cycle.
    pend = '1;
    step(1'b1, 1'b1, 5, 64'hDEAD_BEEF_0000_0005, obs);
    check("free5_ready", obs, 0);
    check("free5_resp_valid", resp_valid_o, 4'b0010);
    check("free5_resp_data", resp_data_o, 64'hDEAD_BEEF_0000_0005);
    check("free5_outstanding", outstanding_o, 7);
    pend = '1;
    step(1'b1, 1'b0, 0, '0, obs);
    check("reuse5_grant", obs, 4'b0001);
    check("reuse5_mshrid", noc2_o.mshrid, 5);
    check("reuse5_outstanding", outstanding_o, 8);
    check("resp_pulse_one_cycle", resp_valid_o, 0);

    // Same-cycle free of id 2 (owner requester 2) while a request waits.
    pend = '1;
    step(1'b1, 1'b1, 2, 64'h1234_5678_9ABC_DEF0, obs);
    check("free2_ready", obs, 0);
    check("free2_resp_valid", resp_valid_o, 4'b0100);
    check("free2_outstanding", outstanding_o, 7);
    pend = '1;
    step(1'b1, 1'b0, 0, '0, obs);
    check("reuse2_mshrid", noc2_o.mshrid, 2);
    check("reuse2_outstanding", outstanding_o, 8);

    // Spurious responses: unallocated id and out-of-range id.
    do_reset();
    step(1'b1, 1'b1, 7, 64'h77, obs);
    check("spur_resp_valid", resp_valid_o, 0);
    check("spur_err", err_spurious_o, 1);
    check("spur_outstanding", outstanding_o, 0);
    step(1'b1, 1'b1, 12, 64'hC, obs);
    step(1'b1, 1'b0, 0, '0, obs);
    check("spur_sticky", err_spurious_o, 1);
    do_reset();

    // Randomized traffic in chunks, each starting from reset (also drops held state).
    for (int chunk = 0; chunk < 4; chunk++) begin
      for (int cyc = 0; cyc < 500; cyc++) begin
        for (int r = 0; r < NUM_REQ; r++)
          if (!pend[r] && $urandom_range(0, 2) == 0) pend[r] = 1'b1;
        ids.delete();
        for (int i = 0; i < NUM_MSHR; i++) if (owner[i] >= 0) ids.push_back(i);
        pick   = $urandom_range(0, 19);
        rsp_v  = 1'b0;
        rsp_id = 0;
        if (pick < 8 && ids.size() > 0) begin
          rsp_v  = 1'b1;
          rsp_id = ids[$urandom_range(0, ids.size() - 1)];
        end else if (pick == 8 && chunk >= 2) begin
          rsp_v  = 1'b1;
          rsp_id = $urandom_range(0, 15);
        end
        step($urandom_range(0, 3) != 0, rsp_v, rsp_id, {$urandom, $urandom}, obs);
      end
      do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
